// File: rtl/jpeg_mcu_pixel_sink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : jpeg_mcu_pixel_sink                                              |
// | Purpose : Consumer end of the decoder pixel-output handshake. Converts     |
// |           MCU-ordered pixels (16x16 4:1:1 or 8x8 geometry) into raster     |
// |           frame-buffer writes, clips them to the image and buffer bounds,  |
// |           and queues them in a FIFO ahead of a stallable buffer port.      |
// |           Raises frame_done once the final write has left the FIFO.        |
// | Ports   : clk, rst                   clock, synchronous active-high reset  |
// |           frame_start                arm for a new frame (pulse)           |
// |           cfg_*                      decoder geometry, latched on cfg_en   |
// |           px_we/px_end/px_rgb/px_adr/px_x_mcu/px_y_mcu  pixel stream       |
// |           px_next                    ready back to the decoder             |
// |           fb_wr_en/addr/data/ready   frame-buffer write port               |
// |           frame_done                 frame fully written (level)           |
// |           pix_written/pix_clipped    saturating per-frame counters         |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module jpeg_mcu_pixel_sink #(
  parameter int FB_W          = 640,
  parameter int FB_H          = 480,
  parameter int FB_ADDR_WIDTH = 19,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     cfg_en,
  input  logic                     cfg_411,
  input  logic [15:0]              cfg_width,
  input  logic [15:0]              cfg_height,
  input  logic [12:0]              cfg_mcu_w,
  input  logic [12:0]              cfg_mcu_h,
  input  logic                     px_we,
  input  logic                     px_end,
  input  logic [23:0]              px_rgb,
  input  logic [7:0]               px_adr,
  input  logic [12:0]              px_x_mcu,
  input  logic [12:0]              px_y_mcu,
  output logic                     px_next,
  output logic                     fb_wr_en,
  output logic [FB_ADDR_WIDTH-1:0] fb_wr_addr,
  output logic [23:0]              fb_wr_data,
  input  logic                     fb_wr_ready,
  output logic                     frame_done,
  output logic [19:0]              pix_written,
  output logic [19:0]              pix_clipped
);

  localparam int          PTR_W   = $clog2(FIFO_DEPTH);
  localparam int          ENTRY_W = FB_ADDR_WIDTH + 24;
  localparam logic [19:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CFG = 3'd1,
    RUN      = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t state, state_nx;

  // Latched frame geometry
  logic        mode_411;
  logic [15:0] img_w, img_h;
  logic [12:0] mcu_w, mcu_h;

  // Stage 1: coordinate / clip register
  logic                     s1_valid, s1_clip;
  logic [FB_ADDR_WIDTH-1:0] s1_addr;
  logic [23:0]              s1_data;

  // Write FIFO
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;

  logic fifo_empty, fifo_full, pop, push, s1_advance;
  logic can_take, accept, last_px, drain_done, restart;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && fb_wr_ready;
  // A clipped pixel never needs a FIFO slot; a kept one may take the slot
  // freed by a same-cycle pop even when the FIFO is full.
  assign s1_advance = s1_valid && (s1_clip || !fifo_full || pop);
  assign push       = s1_advance && !s1_clip;
  assign can_take   = !s1_valid || !fifo_full;
  assign accept     = px_we && px_next;
  assign last_px    = px_we && can_take && px_end &&
                      (px_x_mcu == mcu_w - 13'd1) && (px_y_mcu == mcu_h - 13'd1);
  // Look one cycle ahead so DONE is entered on the edge of the final pop.
  assign drain_done = !s1_valid && (fifo_empty || (count == (PTR_W+1)'(1) && pop));
  assign restart    = frame_start && (state == IDLE || state == WAIT_CFG || state == DONE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    px_next  = 1'b0;
    unique case (state)
      IDLE:     if (frame_start) state_nx = WAIT_CFG;
      WAIT_CFG: if (cfg_en) state_nx = RUN;
      RUN: begin
        px_next = can_take;
        if (last_px) state_nx = DRAIN;
      end
      DRAIN:    if (drain_done) state_nx = DONE;
      DONE:     if (frame_start) state_nx = WAIT_CFG;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_411 <= 1'b0;
      img_w    <= '0;
      img_h    <= '0;
      mcu_w    <= '0;
      mcu_h    <= '0;
    end else if (state == WAIT_CFG && cfg_en) begin
      mode_411 <= cfg_411;
      img_w    <= cfg_width;
      img_h    <= cfg_height;
      mcu_w    <= cfg_mcu_w;
      mcu_h    <= cfg_mcu_h;
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic [16:0]              pos_x, pos_y, lim_w, lim_h;
  logic [FB_ADDR_WIDTH-1:0] pos_addr;

  always_comb begin
    if (mode_411) begin
      pos_x = {px_x_mcu, 4'b0000} + {13'd0, px_adr[3:0]};
      pos_y = {px_y_mcu, 4'b0000} + {13'd0, px_adr[7:4]};
    end else begin
      pos_x = {1'b0, px_x_mcu, 3'b000} + {14'd0, px_adr[2:0]};
      pos_y = {1'b0, px_y_mcu, 3'b000} + {12'd0, px_adr[7:3]};
    end
  end

  assign lim_w    = ({1'b0, img_w} < 17'(FB_W)) ? {1'b0, img_w} : 17'(FB_W);
  assign lim_h    = ({1'b0, img_h} < 17'(FB_H)) ? {1'b0, img_h} : 17'(FB_H);
  // Only meaningful for unclipped pixels, which always fit the buffer.
  assign pos_addr = FB_ADDR_WIDTH'(pos_y) * FB_ADDR_WIDTH'(FB_W) + FB_ADDR_WIDTH'(pos_x);

  always_ff @(posedge clk) begin
    if (rst)             s1_valid <= 1'b0;
    else if (accept)     s1_valid <= 1'b1;
    else if (s1_advance) s1_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_clip <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
    end else if (accept) begin
      s1_clip <= (pos_x >= lim_w) || (pos_y >= lim_h);
      s1_addr <= pos_addr;
      s1_data <= px_rgb;
    end
  end

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {s1_addr, s1_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign fb_wr_en = !fifo_empty;
  // Gate the head entry so the port reads zero while idle and after reset.
  assign {fb_wr_addr, fb_wr_data} = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign frame_done = (state == DONE);

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      pix_written <= '0;
      pix_clipped <= '0;
    end else begin
      if (pop && pix_written != CNT_MAX) pix_written <= pix_written + 1'b1;
      if (s1_advance && s1_clip && pix_clipped != CNT_MAX) pix_clipped <= pix_clipped + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_mcu_pixel_sink.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_jpeg_mcu_pixel_sink                                           |
// | Purpose : Self-checking bench for jpeg_mcu_pixel_sink. Pixels are scored   |
// |           against a plain-arithmetic raster/clip model; each scenario task |
// |           compares observed writes, counters and timing inline.           |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_jpeg_mcu_pixel_sink;
  localparam int FB_W = 640;
  localparam int FB_H = 480;
  localparam int AW   = 19;

  logic clk = 1'b0, rst = 1'b1, frame_start = 1'b0, cfg_en = 1'b0, cfg_411 = 1'b0;
  logic [15:0] cfg_width = '0, cfg_height = '0;
  logic [12:0] cfg_mcu_w = '0, cfg_mcu_h = '0;
  logic px_we = 1'b0, px_end = 1'b0;
  logic [23:0] px_rgb = '0;
  logic [7:0]  px_adr = '0;
  logic [12:0] px_x_mcu = '0, px_y_mcu = '0;
  logic px_next, fb_wr_en, frame_done;
  logic [AW-1:0] fb_wr_addr;
  logic [23:0]   fb_wr_data;
  logic          fb_wr_ready = 1'b0;
  logic [19:0]   pix_written, pix_clipped;

  jpeg_mcu_pixel_sink #(.FB_W(FB_W), .FB_H(FB_H), .FB_ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .cfg_en(cfg_en), .cfg_411(cfg_411),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_mcu_w(cfg_mcu_w), .cfg_mcu_h(cfg_mcu_h),
    .px_we(px_we), .px_end(px_end), .px_rgb(px_rgb), .px_adr(px_adr),
    .px_x_mcu(px_x_mcu), .px_y_mcu(px_y_mcu), .px_next(px_next),
    .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
    .fb_wr_ready(fb_wr_ready), .frame_done(frame_done),
    .pix_written(pix_written), .pix_clipped(pix_clipped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed buffer writes, captured mid-cycle when strobe and ready agree.
  logic [AW+23:0] obs_q[$];
  int last_pop_cyc = -100;
  always @(negedge clk)
    if (!rst && fb_wr_en && fb_wr_ready) begin
      obs_q.push_back({fb_wr_addr, fb_wr_data});
      last_pop_cyc = cyc;
    end

  // Reference model state
  bit m411;
  int img_w, img_h, exp_clip;
  logic [AW+23:0] exp_q[$];
  bit rand_ready = 1'b0;
  int n_tests = 0, n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) fb_wr_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer one pixel for up to 'budget' cycles; on acceptance add its
  // expected effect to the model.
  task automatic send_px(input int xm, input int ym, input int adr, input bit endf,
                         input int budget, output bit to, output int acc_cyc);
    int s, x, y, lw, lh;
    logic [23:0] rgb;
    rgb = 24'($urandom);
    px_x_mcu = 13'(xm); px_y_mcu = 13'(ym); px_adr = 8'(adr);
    px_end = endf; px_rgb = rgb; px_we = 1'b1;
    to = 1'b1; acc_cyc = 0;
    for (int k = 0; k < budget; k++) begin
      if (px_next) begin
        acc_cyc = cyc;
        step();
        to = 1'b0;
        break;
      end
      step();
    end
    px_we = 1'b0; px_end = 1'b0;
    if (!to) begin
      s  = m411 ? 16 : 8;
      x  = xm * s + adr % s;
      y  = ym * s + adr / s;
      lw = (img_w < FB_W) ? img_w : FB_W;
      lh = (img_h < FB_H) ? img_h : FB_H;
      if (x >= lw || y >= lh) exp_clip++;
      else exp_q.push_back({AW'(y * FB_W + x), rgb});
    end
  endtask

  task automatic start_frame(input bit is411, input int w, input int h, input int mw, input int mh);
    obs_q.delete(); exp_q.delete(); exp_clip = 0;
    m411 = is411; img_w = w; img_h = h;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    cfg_411 = is411; cfg_width = 16'(w); cfg_height = 16'(h);
    cfg_mcu_w = 13'(mw); cfg_mcu_h = 13'(mh);
    cfg_en = 1'b1; step(); cfg_en = 1'b0;
  endtask

  task automatic wait_done(output bit to, output int dc);
    to = 1'b1; dc = 0;
    for (int k = 0; k < 3000; k++) begin
      if (frame_done) begin
        to = 1'b0; dc = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fb_wr_ready = 1'b1;
    repeat (3) step();
    n_tests++;
    if ({px_next, fb_wr_en, frame_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: next/en/done=%b required 000", {px_next, fb_wr_en, frame_done});
    end
    n_tests++;
    if (pix_written !== 20'd0 || pix_clipped !== 20'd0) begin
      n_fail++; $display("FAIL reset_counters: written=%0d clipped=%0d required 0/0", pix_written, pix_clipped);
    end
    n_tests++;
    if (fb_wr_addr !== '0 || fb_wr_data !== '0) begin
      n_fail++; $display("FAIL reset_port: addr=%0d data=%h required 0/0", fb_wr_addr, fb_wr_data);
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (px_next !== 1'b0) begin
      n_fail++; $display("FAIL idle_next: px_next=%b required 0", px_next);
    end
  endtask

  task automatic test_t1_raster();
    bit to, anyto, bad;
    int ac, dc;
    rand_ready = 1'b0; fb_wr_ready = 1'b1; anyto = 1'b0;
    start_frame(1'b0, 8, 8, 1, 1);
    for (int a = 0; a < 64; a++) begin
      send_px(0, 0, a, a == 63, 300, to, ac); anyto |= to;
    end
    wait_done(to, dc); anyto |= to;
    n_tests++;
    if (anyto) begin n_fail++; $display("FAIL t1_timeout: stalled, required progress"); end
    bad = (obs_q.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL t1_writes: %0d writes, required %0d in raster order", obs_q.size(), exp_q.size()); end
    n_tests++;
    if (pix_written !== 20'd64 || pix_clipped !== 20'd0) begin
      n_fail++; $display("FAIL t1_counts: written=%0d clipped=%0d required 64/0", pix_written, pix_clipped);
    end
    n_tests++;
    if (dc !== last_pop_cyc + 1) begin
      n_fail++; $display("FAIL t1_done_time: done at %0d required %0d", dc, last_pop_cyc + 1);
    end
  endtask

  task automatic test_t2_latency();
    bit to, anyto;
    int ac, dc;
    rand_ready = 1'b0; fb_wr_ready = 1'b1;
    start_frame(1'b1, 640, 480, 3, 2);
    send_px(2, 1, 8'h35, 1'b1, 300, to, ac); anyto = to;
    wait_done(to, dc); anyto |= to;
    n_tests++;
    if (anyto || obs_q.size() != 1) begin
      n_fail++; $display("FAIL t2_count: %0d writes timeout=%b required 1 write", obs_q.size(), anyto);
    end else begin
      n_tests++;
      if (obs_q[0][AW+23:24] !== AW'(12197)) begin
        n_fail++; $display("FAIL t2_addr: addr=%0d required 12197", obs_q[0][AW+23:24]);
      end
      n_tests++;
      if (obs_q[0] !== exp_q[0]) begin
        n_fail++; $display("FAIL t2_data: entry=%h required %h", obs_q[0], exp_q[0]);
      end
    end
    n_tests++;
    if (last_pop_cyc !== ac + 2) begin
      n_fail++; $display("FAIL t2_latency: write at cycle %0d required %0d", last_pop_cyc, ac + 2);
    end
  endtask

  task automatic test_t3_clip();
    bit to, anyto, bad;
    int ac, dc;
    rand_ready = 1'b0; fb_wr_ready = 1'b1; anyto = 1'b0;
    start_frame(1'b1, 20, 16, 2, 1);
    for (int a = 0; a < 256; a++) begin
      send_px(1, 0, a, a == 255, 300, to, ac); anyto |= to;
    end
    wait_done(to, dc); anyto |= to;
    n_tests++;
    if (anyto) begin n_fail++; $display("FAIL t3_timeout: stalled, required progress"); end
    n_tests++;
    if (pix_clipped !== 20'd192 || pix_written !== 20'd64) begin
      n_fail++; $display("FAIL t3_counts: written=%0d clipped=%0d required 64/192", pix_written, pix_clipped);
    end
    bad = (obs_q.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL t3_writes: %0d writes, required %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_t4_stall();
    bit to, anyto, bad;
    int ac, dc, nacc;
    logic [AW+23:0] held;
    rand_ready = 1'b0; fb_wr_ready = 1'b0; anyto = 1'b0; nacc = 0;
    start_frame(1'b0, 8, 8, 1, 1);
    for (int a = 0; a < 8; a++) begin
      send_px(0, 0, a, 1'b0, 3, to, ac);
      if (to) break;
      nacc++;
    end
    n_tests++;
    if (nacc !== 5) begin n_fail++; $display("FAIL t4_accepts: %0d accepted under stall, required 5", nacc); end
    held = {fb_wr_addr, fb_wr_data};
    repeat (3) step();
    n_tests++;
    if (obs_q.size() != 0 || fb_wr_en !== 1'b1 || px_next !== 1'b0) begin
      n_fail++; $display("FAIL t4_stalled: writes=%0d en=%b next=%b required 0/1/0", obs_q.size(), fb_wr_en, px_next);
    end
    n_tests++;
    if ({fb_wr_addr, fb_wr_data} !== held || held !== exp_q[0]) begin
      n_fail++; $display("FAIL t4_hold: port=%h was %h required %h", {fb_wr_addr, fb_wr_data}, held, exp_q[0]);
    end
    rand_ready = 1'b1;
    for (int a = nacc; a < 64; a++) begin
      send_px(0, 0, a, a == 63, 300, to, ac); anyto |= to;
    end
    wait_done(to, dc); anyto |= to;
    rand_ready = 1'b0; fb_wr_ready = 1'b1;
    bad = anyto || (obs_q.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL t4_order: %0d writes timeout=%b, required %0d in order", obs_q.size(), anyto, exp_q.size()); end
    n_tests++;
    if (pix_written !== 20'd64) begin n_fail++; $display("FAIL t4_written: %0d required 64", pix_written); end
  endtask

  task automatic test_t5_abort();
    bit to, anyto;
    int ac;
    rand_ready = 1'b0; fb_wr_ready = 1'b1; anyto = 1'b0;
    start_frame(1'b0, 16, 16, 2, 2);
    for (int a = 0; a < 6; a++) begin send_px(0, 0, a, 1'b0, 300, to, ac); anyto |= to; end
    frame_start = 1'b1; step(); frame_start = 1'b0;
    n_tests++;
    if (px_next !== 1'b1) begin n_fail++; $display("FAIL t5_ignore_start: px_next=%b required 1", px_next); end
    fb_wr_ready = 1'b0;
    for (int a = 6; a < 10; a++) begin send_px(0, 0, a, 1'b0, 300, to, ac); anyto |= to; end
    n_tests++;
    if (anyto || fb_wr_en !== 1'b1) begin
      n_fail++; $display("FAIL t5_pending: en=%b timeout=%b required 1/0", fb_wr_en, anyto);
    end
    rst = 1'b1; step();
    n_tests++;
    if (fb_wr_en !== 1'b0 || px_next !== 1'b0) begin
      n_fail++; $display("FAIL t5_flush: en=%b next=%b required 0/0", fb_wr_en, px_next);
    end
    n_tests++;
    if (pix_written !== 20'd0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL t5_reset_state: written=%0d done=%b required 0/0", pix_written, frame_done);
    end
    rst = 1'b0; fb_wr_ready = 1'b1; obs_q.delete();
    cfg_en = 1'b1; px_we = 1'b1;
    repeat (3) step();
    n_tests++;
    if (px_next !== 1'b0 || fb_wr_en !== 1'b0 || obs_q.size() != 0) begin
      n_fail++; $display("FAIL t5_idle: next=%b en=%b writes=%0d required 0/0/0", px_next, fb_wr_en, obs_q.size());
    end
    cfg_en = 1'b0; px_we = 1'b0;
  endtask

  task automatic test_t6_drain();
    bit to, anyto, bad;
    int ac, dc;
    rand_ready = 1'b0; fb_wr_ready = 1'b0; anyto = 1'b0;
    start_frame(1'b0, 8, 8, 1, 1);
    for (int a = 0; a < 5; a++) begin send_px(0, 0, a, a == 4, 50, to, ac); anyto |= to; end
    repeat (3) step();
    n_tests++;
    if (anyto || px_next !== 1'b0 || frame_done !== 1'b0 || fb_wr_en !== 1'b1) begin
      n_fail++; $display("FAIL t6_drain_hold: next=%b done=%b en=%b timeout=%b required 0/0/1/0",
                         px_next, frame_done, fb_wr_en, anyto);
    end
    fb_wr_ready = 1'b1;
    wait_done(to, dc);
    n_tests++;
    if (to || dc !== last_pop_cyc + 1) begin
      n_fail++; $display("FAIL t6_done_time: done at %0d required %0d", dc, last_pop_cyc + 1);
    end
    bad = (obs_q.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_tests++;
    if (bad || pix_written !== 20'd5) begin
      n_fail++; $display("FAIL t6_writes: %0d writes written=%0d required 5", obs_q.size(), pix_written);
    end
  endtask

  task automatic test_fb_bound();
    bit to, anyto;
    int ac, dc;
    rand_ready = 1'b0; fb_wr_ready = 1'b1; anyto = 1'b0;
    start_frame(1'b1, 1000, 1000, 41, 31);
    send_px(39, 0, 8'h0F, 1'b0, 300, to, ac); anyto |= to;
    send_px(40, 0, 8'h00, 1'b0, 300, to, ac); anyto |= to;
    send_px(0, 29, 8'hF0, 1'b0, 300, to, ac); anyto |= to;
    send_px(0, 30, 8'h00, 1'b0, 300, to, ac); anyto |= to;
    send_px(40, 30, 8'hFF, 1'b1, 300, to, ac); anyto |= to;
    wait_done(to, dc); anyto |= to;
    n_tests++;
    if (anyto || obs_q.size() != 2) begin
      n_fail++; $display("FAIL bound_count: %0d writes timeout=%b required 2", obs_q.size(), anyto);
    end else begin
      n_tests++;
      if (obs_q[0][AW+23:24] !== AW'(639) || obs_q[1][AW+23:24] !== AW'(306560)) begin
        n_fail++; $display("FAIL bound_addr: %0d,%0d required 639,306560", obs_q[0][AW+23:24], obs_q[1][AW+23:24]);
      end
    end
    n_tests++;
    if (pix_written !== 20'd2 || pix_clipped !== 20'd3) begin
      n_fail++; $display("FAIL bound_counts: written=%0d clipped=%0d required 2/3", pix_written, pix_clipped);
    end
  endtask

  task automatic test_random();
    bit to, anyto, bad, is411;
    int ac, dc, s, mw, mh, w, h;
    for (int f = 0; f < 3; f++) begin
      is411 = 1'($urandom_range(0, 1));
      s  = is411 ? 16 : 8;
      mw = $urandom_range(1, 2); mh = $urandom_range(1, 2);
      w  = $urandom_range(1, mw * s + 4); h = $urandom_range(1, mh * s + 4);
      rand_ready = 1'b1; anyto = 1'b0;
      start_frame(is411, w, h, mw, mh);
      n_tests++;
      if (pix_written !== 20'd0 || pix_clipped !== 20'd0 || frame_done !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d_clear: written=%0d clipped=%0d done=%b required 0/0/0",
                           f, pix_written, pix_clipped, frame_done);
      end
      for (int ym = 0; ym < mh; ym++)
        for (int xm = 0; xm < mw; xm++)
          for (int a = 0; a < s * s; a++) begin
            if ($urandom_range(0, 3) == 0) step();
            send_px(xm, ym, a, a == s * s - 1, 300, to, ac); anyto |= to;
          end
      wait_done(to, dc); anyto |= to;
      bad = anyto || (obs_q.size() != exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
      n_tests++;
      if (bad) begin
        n_fail++; $display("FAIL rnd%0d_writes: %0d writes timeout=%b required %0d (w=%0d h=%0d 411=%b)",
                           f, obs_q.size(), anyto, exp_q.size(), w, h, is411);
      end
      n_tests++;
      if (pix_written !== 20'(exp_q.size()) || pix_clipped !== 20'(exp_clip)) begin
        n_fail++; $display("FAIL rnd%0d_counts: written=%0d clipped=%0d required %0d/%0d",
                           f, pix_written, pix_clipped, exp_q.size(), exp_clip);
      end
      rand_ready = 1'b0; fb_wr_ready = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_t1_raster();
    test_t2_latency();
    test_t3_clip();
    test_t4_stall();
    test_t5_abort();
    test_t6_drain();
    test_fb_bound();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
